// File: rtl/mux41_rr_if.sv
// Bus bundle between the requesters and the round-robin mux arbiter:
// request/data lines in, grant/select/registered data out.
interface mux41_rr_if;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       out;

    // Requester side: drives requests and data, observes the grant.
    modport master (
        output req,
        output in,
        input  gnt,
        input  sel,
        input  valid,
        input  out
    );

    // Arbiter side: samples requests and data, drives grant, select and data.
    modport slave (
        input  req,
        input  in,
        output gnt,
        output sel,
        output valid,
        output out
    );
endinterface

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 bit mux.
// One requester holds the grant at a time. A tenure is capped at HOLD_MAX
// cycles only when somebody else is waiting. The selected data bit is
// re-registered so downstream logic sees a glitch-free output. Every output
// comes straight from a flop.
module mux41_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    mux41_rr_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    state_t           state_r;
    logic [1:0]       ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       gnt_r;
    logic [1:0]       sel_r;
    logic             valid_r;
    logic             out_r;

    logic [1:0]       search_ptr_s;
    logic [3:0]       search_req_s;
    logic [2:0]       pick_s;
    logic             found_s;
    logic [1:0]       win_s;

    // First set request bit scanning p, p+1, p+2, p+3 (mod 4).
    // Returns {found, index}. The scan runs from the farthest offset down so
    // the nearest hit is the one left in the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner search. In IDLE the scan starts at ptr over all requests. In
    // GRANT it starts one past the current grantee and skips the grantee.
    // That start point is the pointer value a release or preemption commits,
    // so the same winner serves rules 1 and 2.
    always_comb begin
        search_ptr_s = ptr_r;
        search_req_s = bus.req;
        if (state_r == ST_GRANT) begin
            search_ptr_s = sel_r + 2'd1;
            search_req_s = bus.req & ~gnt_r;
        end else begin
            search_ptr_s = ptr_r;
            search_req_s = bus.req;
        end
        pick_s  = rr_pick(search_req_s, search_ptr_s);
        found_s = pick_s[2];
        win_s   = pick_s[1:0];
    end

    // Arbitration FSM with registered grant, select, valid and data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= '0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            valid_r <= 1'b0;
            out_r   <= 1'b0;
        end else begin
            // Data follows the pre-edge select, so out lags sel by one cycle.
            out_r <= valid_r ? bus.in[sel_r] : 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt_r   <= 4'b0001 << win_s;
                        sel_r   <= win_s;
                        valid_r <= 1'b1;
                        cnt_r   <= CNT_ONE_C;
                        state_r <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!bus.req[sel_r]) begin
                        // Release wins over a simultaneous hold expiry.
                        ptr_r <= sel_r + 2'd1;
                        if (found_s) begin
                            gnt_r   <= 4'b0001 << win_s;
                            sel_r   <= win_s;
                            valid_r <= 1'b1;
                            cnt_r   <= CNT_ONE_C;
                            state_r <= ST_GRANT;
                        end else begin
                            // sel is held so the last data bit can still drain.
                            gnt_r   <= 4'b0000;
                            valid_r <= 1'b0;
                            cnt_r   <= '0;
                            state_r <= ST_IDLE;
                        end
                    end else if ((cnt_r == HOLD_MAX_C) && found_s) begin
                        // Tenure expired with another requester waiting.
                        ptr_r   <= sel_r + 2'd1;
                        gnt_r   <= 4'b0001 << win_s;
                        sel_r   <= win_s;
                        valid_r <= 1'b1;
                        cnt_r   <= CNT_ONE_C;
                    end else if (cnt_r == HOLD_MAX_C) begin
                        // Lone requester: keep the grant, counter saturates.
                        cnt_r <= HOLD_MAX_C;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE_C;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 4'b0000;
                    valid_r <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.sel   = sel_r;
    assign bus.valid = valid_r;
    assign bus.out   = out_r;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter (HOLD_MAX=4). The driver applies one
// vector per cycle on the falling edge and queues the hand-computed outputs
// expected after the next rising edge. An asynchronous reset assertion also
// queues an immediate expectation. The monitor pops one entry and compares it
// 1 ns after every rising clock edge or reset edge.
module tb_mux41_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       out;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    mux41_rr_if bus ();

    mux41_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector on the falling edge and queue what the DUT must show.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic ev, input logic eo);
        exp_t e;
        @(negedge clk);
        e.gnt   = eg;
        e.sel   = es;
        e.valid = ev;
        e.out   = eo;
        if (r && !rst) begin
            // The reset clears the DUT straight away, not at the next edge.
            exp_q.push_back('0);
        end else begin
            e = e;
        end
        exp_q.push_back(e);
        rst     = r;
        bus.req = rq;
        bus.in  = d;
    endtask

    // Monitor: compare outputs with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e) begin
                    n_errors++;
                    $display("FAIL check%0d t=%0t gnt/sel/valid/out got %b/%b/%b/%b want %b/%b/%b/%b",
                             n_checks, $time, bus.gnt, bus.sel, bus.valid, bus.out,
                             e.gnt, e.sel, e.valid, e.out);
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.in   = 4'b0000;

        // 1. Reset, then a single requester.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
        step(1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2. Fairness: all four request. Each tenure lasts 4 cycles, with no gaps.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
        step(1'b0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b1);
        repeat (3) step(1'b0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
        repeat (3) step(1'b0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
        step(1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1);

        // 3. Early release hands over without a bubble, then the bus goes idle.
        step(1'b0, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1);
        step(1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);

        // 4. A lone requester keeps the grant past HOLD_MAX. A late arrival preempts.
        step(1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        repeat (9) step(1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
        step(1'b0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b1);

        // 5. Grantee 3 drops at hold expiry as req[0] rises: pointer wraps to 0.
        repeat (3) step(1'b0, 4'b1000, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);
        step(1'b0, 4'b0001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);
        step(1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);

        // 6. Asynchronous reset mid-grant. Arbitration restarts from requester 0.
        step(1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);

        // Let the monitor drain, then confirm nothing was left unchecked.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
Round-robin arbiter and select sequencer for the shared 4:1 bit multiplexer.
- Four requesters share one output bit. The block grants one requester at a time and drives the 2-bit select for the mux.
- It limits each tenure to HOLD_MAX cycles when others are waiting.
- It registers the selected data bit so downstream logic sees a clean, glitch-free output.

Parameters:
HOLD_MAX, 4, maximum consecutive grant cycles while another requester is pending; legal range 1..7.
CNT_W, 3, width of the hold counter; must satisfy HOLD_MAX <= 2^CNT_W-1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  level request, one bit per requester; bit i = requester i
in  input  4  mux data inputs; bit i belongs to requester i
gnt  output  4  registered one-hot grant; all-zero when idle
sel  output  2  registered mux select, equal to the index of the granted bit; drives the 4:1 mux
valid  output  1  registered; 1 while any grant is active
out  output  1  registered data: in[sel] captured on each edge where valid=1, else 0

Behaviour:
- Reset (async, rst=1):
  - gnt=0000, sel=00, valid=0, out=0.
  - State=IDLE, ptr=0, cnt=0.
  - Deassertion takes effect at the next clk edge.
- ptr: 2-bit round-robin pointer. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). First set req bit wins.
- State IDLE:
  - If req==0000: stay in IDLE.
  - Else, at the edge: grant winner k, so gnt=1<<k, sel=k, valid=1, cnt=1, state=GRANT.
  - Latency from req sampled high to gnt visible: 1 cycle.
- State GRANT (k = current grantee), evaluated at each edge, first match wins:
  1. req[k]==0: release k and set ptr=k+1. If any other req is set, grant the next winner from ptr in the same edge (no idle bubble), cnt=1. Else go to IDLE with gnt=0000, valid=0, sel held.
  2. cnt==HOLD_MAX and any other req bit is set (preemption): ptr=k+1, grant next winner from ptr, cnt=1.
  3. cnt==HOLD_MAX and no other req: keep k, cnt saturates at HOLD_MAX.
  4. Otherwise: keep k, cnt=cnt+1.
- out: on each edge, out <= valid ? in[sel] : 0, using the pre-edge registered sel/valid. out therefore lags sel by one cycle.
- On the cycle after a release to IDLE, out shows the last granted bit once, then 0.
- Wrap-around: ptr=3+1 wraps to 0. A grantee of 3 passes priority to 0.
- Simultaneous events: a requester dropping in the same edge that cnt hits HOLD_MAX is treated as a release (rule 1). A new request arriving on the same edge as a release is eligible immediately.
- Invariants:
  - gnt is always one-hot or zero.
  - sel==index(gnt) whenever valid=1.
  - No requester waits more than 3*HOLD_MAX+3 cycles while continuously requesting.
- Reset mid-grant: outputs clear immediately (asynchronously). After reset, arbitration restarts from ptr=0.
- Synthesizable. No latches. All outputs come directly from flops.

Test Plan:
1. Reset then single request: rst pulse, req=0001, in=1000 -> one cycle later gnt=0001, sel=00, valid=1. Next cycle out=in[0]=0. Set in=0001 -> out=1 one cycle later.
2. Round-robin fairness: req=1111 held, HOLD_MAX=4 -> grants rotate 0,1,2,3,0, each lasting exactly 4 cycles with no gap cycles. sel sequence is 00,01,10,11.
3. Early release and back-to-back: req=0101, grantee 0 drops req after 2 cycles -> on the next edge gnt=0100, sel=10, cnt=1, valid stays 1. Drop req[2] -> gnt=0000, valid=0. out shows in[2] once, then 0.
4. Saturation with lone requester: req=0010 held for 10 cycles -> gnt=0010 throughout, no re-arbitration. Raise req[3] at cycle 10 -> gnt=1000 on the next edge.
5. Wrap and simultaneous event: grantee 3 with cnt=HOLD_MAX drops req on the same edge req[0] rises -> gnt=0001, ptr now points past 3 to 0, sel=00.
6. Async reset mid-grant: assert rst between edges while gnt=0100 -> gnt=0000, valid=0, out=0 immediately. After release with req=1111, the first grant is 0001.
